// File: rtl/dlfloat16_issue_decoder.sv
// Registered DLFloat16 FPU issue decoder: instruction FIFO, decode, output register, div/sqrt hazard hold.
// Optional build macro DLF_ILLEGAL_TRAP_EN: drop illegal heads and raise a sticky trap instead of issuing them.
`timescale 1ns/1ps
module dlfloat16_issue_decoder #(
  parameter int         DEPTH    = 4,
  parameter int         DIV_LAT  = 8,
  parameter int         SQRT_LAT = 8,
  parameter logic [6:0] OPC_FP   = 7'b1011011,
  parameter logic [6:0] OPC_FMA  = 7'b0011011,
  parameter logic [6:0] OPC_FMS  = 7'b0111011
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              instr,
  input  logic [2:0]               frm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               ena,
  output logic                     op,
  output logic [2:0]               rm,
  output logic [1:0]               sel1,
  output logic [2:0]               sel2,
  output logic [4:0]               rd,
  output logic [4:0]               rs1,
  output logic [4:0]               rs2,
  output logic [4:0]               rs3,
  output logic                     illegal,
  output logic [$clog2(DEPTH):0]   count
`ifdef DLF_ILLEGAL_TRAP_EN
  ,
  input  logic                     trap_clr,
  output logic                     trap
`endif
);

  localparam int PW     = $clog2(DEPTH);
  localparam int CW     = PW + 1;
  localparam int MAXLAT = (DIV_LAT > SQRT_LAT) ? DIV_LAT : SQRT_LAT;
  localparam int BW     = (MAXLAT < 1) ? 1 : $clog2(MAXLAT + 1);

  localparam logic [3:0] ENA_DIV  = 4'b0011;
  localparam logic [3:0] ENA_SQRT = 4'b0100;

  // FIFO entry: {frm, instr}
  logic [34:0]   mem_q [DEPTH];
  logic [34:0]   mem_d [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] busy_q, busy_d;

  logic          out_valid_q, out_valid_d;
  logic [3:0]    ena_q, ena_d;
  logic          op_q, op_d;
  logic [2:0]    rm_q, rm_d;
  logic [1:0]    sel1_q, sel1_d;
  logic [2:0]    sel2_q, sel2_d;
  logic [4:0]    rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;
`ifdef DLF_ILLEGAL_TRAP_EN
  logic          trap_q, trap_d;
`else
  logic          illegal_q, illegal_d;
`endif

  logic [34:0] head;
  logic [31:0] h_instr;
  logic [2:0]  h_frm, rmf;
  logic [6:0]  opc;
  logic [4:0]  fun5;
  logic [3:0]  dec_ena;
  logic        dec_op, dec_ill, arith;
  logic [2:0]  dec_rm, dec_sel2;
  logic [1:0]  dec_sel1;
  logic        head_valid, head_divsqrt, issue, issue_divsqrt, blocked;
  logic        slot_free, push, pop, load, drop;
  logic        unused_fmt;

  assign head       = mem_q[rptr_q];
  assign h_instr    = head[31:0];
  assign h_frm      = head[34:32];
  assign opc        = h_instr[6:0];
  assign rmf        = h_instr[14:12];
  assign fun5       = h_instr[31:27];
  assign unused_fmt = ^h_instr[26:25];

  always_comb begin
    dec_ena  = '0;
    dec_op   = 1'b0;
    dec_rm   = '0;
    dec_sel1 = '0;
    dec_sel2 = '0;
    dec_ill  = 1'b0;
    arith    = 1'b0;
    if (opc == OPC_FP) begin
      case (fun5)
        5'b00000: begin dec_ena = 4'b0001; arith = 1'b1; end
        5'b00001: begin dec_ena = 4'b0001; dec_op = 1'b1; arith = 1'b1; end
        5'b00010: begin dec_ena = 4'b0010; arith = 1'b1; end
        5'b00011: begin dec_ena = ENA_DIV; arith = 1'b1; end
        5'b01011: begin dec_ena = ENA_SQRT; arith = 1'b1; end
        5'b01000: begin dec_ena = 4'b0111; arith = 1'b1; end
        5'b01001: begin dec_ena = 4'b1000; arith = 1'b1; end
        5'b00100: begin
          dec_rm = rmf;
          case (rmf)
            3'b000:  begin dec_ena = 4'b0101; dec_sel1 = 2'b01; end
            3'b001:  begin dec_ena = 4'b0101; dec_sel1 = 2'b10; end
            3'b010:  begin dec_ena = 4'b0101; dec_sel1 = 2'b11; end
            default: ;
          endcase
        end
        5'b00101: begin
          dec_rm = rmf;
          case (rmf)
            3'b000:  begin dec_ena = 4'b0110; dec_sel2 = 3'b001; end
            3'b001:  begin dec_ena = 4'b0110; dec_sel2 = 3'b010; end
            default: ;
          endcase
        end
        5'b10100: begin
          dec_rm = rmf;
          case (rmf)
            3'b010:  begin dec_ena = 4'b0110; dec_sel2 = 3'b011; end
            3'b001:  begin dec_ena = 4'b0110; dec_sel2 = 3'b100; end
            3'b000:  begin dec_ena = 4'b0110; dec_sel2 = 3'b101; end
            default: ;
          endcase
        end
        default: ;
      endcase
    end else if (opc == OPC_FMA) begin
      dec_ena = 4'b1001;
      arith   = 1'b1;
    end else if (opc == OPC_FMS) begin
      dec_ena = 4'b1001;
      dec_op  = 1'b1;
      arith   = 1'b1;
    end
    if (arith) begin
      if (rmf == 3'b101 || rmf == 3'b110) dec_ena = '0;
      else dec_rm = (rmf == 3'b111) ? h_frm : rmf;
    end
    // anything left without a unit is an illegal beat with cleared control fields
    if (dec_ena == '0) begin
      dec_op   = 1'b0;
      dec_rm   = '0;
      dec_sel1 = '0;
      dec_sel2 = '0;
      dec_ill  = 1'b1;
    end
  end

  assign head_valid    = (count_q != '0);
  assign head_divsqrt  = (dec_ena == ENA_DIV) || (dec_ena == ENA_SQRT);
  assign issue         = out_valid_q && out_ready;
  assign issue_divsqrt = issue && ((ena_q == ENA_DIV) || (ena_q == ENA_SQRT));
  assign blocked       = head_divsqrt && ((busy_q != '0) || issue_divsqrt);
  assign slot_free     = !out_valid_q || out_ready;
  assign in_ready      = (count_q < CW'(DEPTH));
  assign push          = in_valid && in_ready;
`ifdef DLF_ILLEGAL_TRAP_EN
  assign drop = head_valid && dec_ill;
  assign load = head_valid && !dec_ill && slot_free && !blocked;
`else
  assign drop = 1'b0;
  assign load = head_valid && slot_free && !blocked;
`endif
  assign pop = load || drop;

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      mem_d[wptr_q] = {frm, instr};
      wptr_d        = wptr_q + PW'(1);
    end
    if (pop) rptr_d = rptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    ena_d  = ena_q;
    op_d   = op_q;
    rm_d   = rm_q;
    sel1_d = sel1_q;
    sel2_d = sel2_q;
    rd_d   = rd_q;
    rs1_d  = rs1_q;
    rs2_d  = rs2_q;
    rs3_d  = rs3_q;
`ifndef DLF_ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    if (load) begin
      out_valid_d = 1'b1;
      ena_d  = dec_ena;
      op_d   = dec_op;
      rm_d   = dec_rm;
      sel1_d = dec_sel1;
      sel2_d = dec_sel2;
      rd_d   = h_instr[11:7];
      rs1_d  = h_instr[19:15];
      rs2_d  = h_instr[24:20];
      rs3_d  = h_instr[31:27];
`ifndef DLF_ILLEGAL_TRAP_EN
      illegal_d = dec_ill;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (issue && ena_q == ENA_DIV)       busy_d = BW'(DIV_LAT);
    else if (issue && ena_q == ENA_SQRT) busy_d = BW'(SQRT_LAT);
    else if (busy_q != '0)               busy_d = busy_q - BW'(1);
    else                                 busy_d = busy_q;

`ifdef DLF_ILLEGAL_TRAP_EN
    trap_d = trap_q;
    if (trap_clr) trap_d = 1'b0;
    if (drop)     trap_d = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      ena_q       <= '0;
      op_q        <= 1'b0;
      rm_q        <= '0;
      sel1_q      <= '0;
      sel2_q      <= '0;
      rd_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs3_q       <= '0;
`ifdef DLF_ILLEGAL_TRAP_EN
      trap_q      <= 1'b0;
`else
      illegal_q   <= 1'b0;
`endif
    end else begin
      mem_q       <= mem_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      ena_q       <= ena_d;
      op_q        <= op_d;
      rm_q        <= rm_d;
      sel1_q      <= sel1_d;
      sel2_q      <= sel2_d;
      rd_q        <= rd_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rs3_q       <= rs3_d;
`ifdef DLF_ILLEGAL_TRAP_EN
      trap_q      <= trap_d;
`else
      illegal_q   <= illegal_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign ena       = ena_q;
  assign op        = op_q;
  assign rm        = rm_q;
  assign sel1      = sel1_q;
  assign sel2      = sel2_q;
  assign rd        = rd_q;
  assign rs1       = rs1_q;
  assign rs2       = rs2_q;
  assign rs3       = rs3_q;
  assign count     = count_q;
`ifdef DLF_ILLEGAL_TRAP_EN
  assign illegal   = 1'b0;
  assign trap      = trap_q;
`else
  assign illegal   = illegal_q;
`endif

endmodule
